// File: rtl/hand_bank_pkg.sv
// Card encoding shared by the hand bank: codes 1..13 = A..K, 0 = empty slot.
// Also holds the baccarat point value of a card.
package card_pkg;
  typedef logic [3:0] card_t;

  localparam card_t      CARD_EMPTY  = 4'd0;
  localparam card_t      CARD_MAX    = 4'd13;
  localparam logic [3:0] NATURAL_MIN = 4'd8;

  // Ten and the face cards are worth nothing in baccarat
  function automatic logic [3:0] card_value(card_t c);
    return (c != CARD_EMPTY && c <= 4'd9) ? c : 4'd0;
  endfunction
endpackage

// File: rtl/hand_bank_if.sv
// Deal/clear request port of the hand bank. The card source drives it
// (master); the bank answers with a combinational deal_ready (slave).
interface hand_bank_if #(
  parameter int N_HANDS = 2,
  parameter int CARD_W  = 4
);
  localparam int HW = (N_HANDS > 1) ? $clog2(N_HANDS) : 1;

  logic              deal_valid;
  logic [HW-1:0]     deal_hand;
  logic [CARD_W-1:0] deal_card;
  logic              deal_ready;
  logic              clear_valid;
  logic [HW-1:0]     clear_hand;

  modport master (
    output deal_valid, deal_hand, deal_card, clear_valid, clear_hand,
    input  deal_ready
  );

  modport slave (
    input  deal_valid, deal_hand, deal_card, clear_valid, clear_hand,
    output deal_ready
  );
endinterface

// File: rtl/hand_bank_slot.sv
// One hand: slot registers, card count and running baccarat score.
// The caller only asserts load when the hand has a free slot.
module hand_slot
  import card_pkg::*;
#(
  parameter int MAX_CARDS = 3,
  parameter int CARD_W    = 4,
  parameter int CW        = $clog2(MAX_CARDS + 1)
) (
  input  logic                              slow_clock,
  input  logic                              resetb,
  input  logic                              load,
  input  logic                              clr,
  input  logic [CARD_W-1:0]                 card,
  output logic [MAX_CARDS-1:0][CARD_W-1:0]  slots,
  output logic [CW-1:0]                     count,
  output logic [3:0]                        score
);
  logic [MAX_CARDS-1:0][CARD_W-1:0] slots_q, slots_d;
  logic [CW-1:0]                    count_q, count_d;
  logic [3:0]                       score_q, score_d;
  logic [4:0]                       sum;

  always_comb begin
    slots_d = slots_q;
    count_d = count_q;
    score_d = score_q;
    sum     = {1'b0, score_q} + {1'b0, card_value(card_t'(card))};
    if (clr) begin
      slots_d = '0;
      count_d = '0;
      score_d = '0;
    end else if (load) begin
      // Append into the next free slot; earlier slots are never touched
      for (int s = 0; s < MAX_CARDS; s++)
        if (count_q == CW'(s)) slots_d[s] = card;
      count_d = count_q + CW'(1);
      score_d = (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      slots_q <= '0;
      count_q <= '0;
      score_q <= '0;
    end else begin
      slots_q <= slots_d;
      count_q <= count_d;
      score_q <= score_d;
    end
  end

  assign slots = slots_q;
  assign count = count_q;
  assign score = score_q;
endmodule

// File: rtl/hand_bank.sv
// Bank of N_HANDS card hands: deal/clear decode, deal_ready, rejected-deal
// pulse and flattening of per-hand state onto the output buses.
module hand_bank
  import card_pkg::*;
#(
  parameter int N_HANDS   = 2,
  parameter int MAX_CARDS = 3,
  parameter int CARD_W    = 4,
  parameter int HW        = (N_HANDS > 1) ? $clog2(N_HANDS) : 1,
  parameter int CW        = $clog2(MAX_CARDS + 1)
) (
  input  logic                                slow_clock,
  input  logic                                resetb,
  hand_bank_if.slave                          bus,
  output logic [N_HANDS*MAX_CARDS*CARD_W-1:0] cards,
  output logic [N_HANDS*CW-1:0]               count,
  output logic [N_HANDS*4-1:0]                score,
  output logic [N_HANDS-1:0]                  full,
  output logic [N_HANDS-1:0]                  natural,
  output logic                                deal_err
);
  logic [N_HANDS-1:0][MAX_CARDS-1:0][CARD_W-1:0] slots_w;
  logic [N_HANDS-1:0][CW-1:0]                    count_w;
  logic [N_HANDS-1:0][3:0]                       score_w;
  logic [N_HANDS-1:0]                            load, clr;

  logic hand_ok, full_sel, clash, card_ok, accept;
  logic deal_err_q, deal_err_d;

  // deal_ready deliberately ignores deal_card; a bad code is caught by card_ok
  always_comb begin
    hand_ok  = {1'b0, bus.deal_hand} < (HW+1)'(N_HANDS);
    full_sel = hand_ok ? full[bus.deal_hand] : 1'b1;
    clash    = bus.clear_valid && (bus.clear_hand == bus.deal_hand);
    card_ok  = (int'(bus.deal_card) >= 1) && (int'(bus.deal_card) <= int'(CARD_MAX));
    accept   = bus.deal_valid && bus.deal_ready && card_ok;
    deal_err_d = bus.deal_valid && !accept;
  end

  assign bus.deal_ready = hand_ok && !full_sel && !clash;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) deal_err_q <= 1'b0;
    else         deal_err_q <= deal_err_d;
  end

  assign deal_err = deal_err_q;

  for (genvar h = 0; h < N_HANDS; h++) begin : g_hand
    // Out-of-range clear_hand matches no hand and is silently dropped
    assign load[h] = accept && (bus.deal_hand == HW'(h));
    assign clr[h]  = bus.clear_valid && (bus.clear_hand == HW'(h));

    hand_slot #(
      .MAX_CARDS (MAX_CARDS),
      .CARD_W    (CARD_W),
      .CW        (CW)
    ) u_hand (
      .slow_clock (slow_clock),
      .resetb     (resetb),
      .load       (load[h]),
      .clr        (clr[h]),
      .card       (bus.deal_card),
      .slots      (slots_w[h]),
      .count      (count_w[h]),
      .score      (score_w[h])
    );

    assign full[h]    = (count_w[h] == CW'(MAX_CARDS));
    assign natural[h] = (count_w[h] == CW'(2)) && (score_w[h] >= NATURAL_MIN);
  end

  assign cards = slots_w;
  assign count = count_w;
  assign score = score_w;
endmodule

// File: tb/tb_hand_bank.sv
// Bench for hand_bank: directed vector table, async reset sequence and
// randomized traffic against a queue-per-hand reference model.
module tb_hand_bank;
  localparam int N   = 3;
  localparam int MAX = 3;
  localparam int CWD = 4;
  localparam int HWT = 2;
  localparam int CWT = 2;

  logic                   clk = 1'b0;
  logic                   resetb = 1'b0;
  logic [N*MAX*CWD-1:0]   cards;
  logic [N*CWT-1:0]       count;
  logic [N*4-1:0]         score;
  logic [N-1:0]           full, natural;
  logic                   deal_err;

  hand_bank_if #(.N_HANDS(N), .CARD_W(CWD)) bus ();

  hand_bank #(.N_HANDS(N), .MAX_CARDS(MAX), .CARD_W(CWD)) dut (
    .slow_clock (clk),
    .resetb     (resetb),
    .bus        (bus),
    .cards      (cards),
    .count      (count),
    .score      (score),
    .full       (full),
    .natural    (natural),
    .deal_err   (deal_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mq [N][$];
  bit m_err;

  typedef struct {
    bit dv; int dh; int dc; bit cv; int ch;
    int c0; int s0; int c1; int s1; bit err;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int m_score(int h);
    int s = 0;
    foreach (mq[h][i]) s += (mq[h][i] <= 9) ? mq[h][i] : 0;
    return s % 10;
  endfunction

  task automatic check_outputs();
    for (int h = 0; h < N; h++) begin
      int sz = mq[h].size();
      int sc = m_score(h);
      chk($sformatf("count%0d", h), int'(count[h*CWT +: CWT]), sz);
      chk($sformatf("score%0d", h), int'(score[h*4 +: 4]), sc);
      chk($sformatf("full%0d", h), int'(full[h]), int'(sz == MAX));
      chk($sformatf("natural%0d", h), int'(natural[h]), int'(sz == 2 && sc >= 8));
      for (int s = 0; s < MAX; s++)
        chk($sformatf("card%0d_%0d", h, s), int'(cards[(h*MAX+s)*CWD +: CWD]),
            (s < sz) ? mq[h][s] : 0);
    end
    chk("deal_err", int'(deal_err), int'(m_err));
  endtask

  // Called just after a negedge; returns just after the following negedge
  task automatic step(bit dv, int dh, int dc, bit cv, int ch);
    bit rdy, acc;
    bus.deal_valid  = dv;
    bus.deal_hand   = dh[HWT-1:0];
    bus.deal_card   = dc[CWD-1:0];
    bus.clear_valid = cv;
    bus.clear_hand  = ch[HWT-1:0];
    #1;
    rdy = (dh < N);
    if (rdy) rdy = (mq[dh].size() < MAX) && !(cv && ch == dh);
    chk("deal_ready", int'(bus.deal_ready), int'(rdy));
    acc = dv && rdy && dc >= 1 && dc <= 13;
    @(posedge clk);
    if (cv && ch < N) mq[ch].delete();
    if (acc) mq[dh].push_back(dc);
    m_err = dv && !acc;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    // dv dh dc cv ch | c0 s0 c1 s1 err
    tbl.push_back('{1,0, 7,0,0, 1,7,0,0,0});
    tbl.push_back('{1,0, 4,0,0, 2,1,0,0,0});
    tbl.push_back('{1,1, 9,0,0, 2,1,1,9,0});
    tbl.push_back('{1,1,13,0,0, 2,1,2,9,0});
    tbl.push_back('{1,1, 5,0,0, 2,1,3,4,0});
    tbl.push_back('{1,0, 2,0,0, 3,3,3,4,0});
    tbl.push_back('{1,0, 3,0,0, 3,3,3,4,1});
    tbl.push_back('{0,0, 0,0,0, 3,3,3,4,0});
    tbl.push_back('{0,0, 0,1,1, 3,3,0,0,0});
    tbl.push_back('{1,1, 0,0,0, 3,3,0,0,1});
    tbl.push_back('{1,1,14,0,0, 3,3,0,0,1});
    tbl.push_back('{0,0, 0,0,0, 3,3,0,0,0});
    tbl.push_back('{1,1, 2,0,0, 3,3,1,2,0});
    tbl.push_back('{1,1, 6,0,0, 3,3,2,8,0});
    tbl.push_back('{1,1, 3,1,1, 3,3,0,0,1});
    tbl.push_back('{0,0, 0,1,0, 0,0,0,0,0});
    tbl.push_back('{1,1, 4,0,0, 0,0,1,4,0});
    tbl.push_back('{1,0, 8,1,1, 1,8,0,0,0});
    tbl.push_back('{1,3, 5,0,0, 1,8,0,0,1});
    tbl.push_back('{0,0, 0,1,3, 1,8,0,0,0});

    bus.deal_valid = 0; bus.deal_hand = '0; bus.deal_card = '0;
    bus.clear_valid = 0; bus.clear_hand = '0;
    m_err = 0;
    repeat (2) @(negedge clk);
    check_outputs();
    resetb = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].dv, tbl[i].dh, tbl[i].dc, tbl[i].cv, tbl[i].ch);
      chk($sformatf("v%0d_c0", i), int'(count[0 +: CWT]), tbl[i].c0);
      chk($sformatf("v%0d_s0", i), int'(score[3:0]), tbl[i].s0);
      chk($sformatf("v%0d_c1", i), int'(count[CWT +: CWT]), tbl[i].c1);
      chk($sformatf("v%0d_s1", i), int'(score[7:4]), tbl[i].s1);
      chk($sformatf("v%0d_err", i), int'(deal_err), int'(tbl[i].err));
    end

    // Fill hand 0 to three cards, then reset between clock edges
    step(1, 0, 5, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("pre_rst_c0", int'(count[0 +: CWT]), 3);
    bus.deal_valid = 0; bus.clear_valid = 0;
    #1 resetb = 1'b0;
    #1;
    for (int h = 0; h < N; h++) mq[h].delete();
    m_err = 0;
    check_outputs();
    chk("rst_cards_all", int'(cards == '0), 1);
    #1 resetb = 1'b1;
    @(negedge clk);
    step(1, 0, 9, 0, 0);
    chk("post_rst_s0", int'(score[3:0]), 9);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 15),
           $urandom_range(0, 7) == 0, $urandom_range(0, 3));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end
endmodule
